// File: rtl/wb_stage_pkg.sv
// Constants shared by the writeback stage, the decode stage and the register file.
package wb_stage_pkg;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned RADDR_W  = 4;
  localparam int unsigned NUM_REGS = 16;
endpackage

// File: rtl/wb_stage_if.sv
// EXE-to-writeback bundle: instruction handoff, load responses, RF write port, scoreboard.
interface wb_stage_if
  import wb_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = wb_stage_pkg::DATA_W,
  parameter int unsigned RADDR_W = wb_stage_pkg::RADDR_W
);
  logic                ex_valid;
  logic                ex_ready;
  logic [RADDR_W-1:0]  ex_rd;
  logic [DATA_W-1:0]   ex_result;
  logic                ex_is_load;
  logic                ex_writes_rd;
  logic                ld_rsp_valid;
  logic [DATA_W-1:0]   ld_rsp_data;
  logic [RADDR_W-1:0]  wb_addr;
  logic [DATA_W-1:0]   wb_data;
  logic                wb_wen;
  logic [NUM_REGS-1:0] busy_mask;
  logic                err_unexpected_rsp;

  modport master (
    output ex_valid, ex_rd, ex_result, ex_is_load, ex_writes_rd, ld_rsp_valid, ld_rsp_data,
    input  ex_ready, wb_addr, wb_data, wb_wen, busy_mask, err_unexpected_rsp
  );

  modport slave (
    input  ex_valid, ex_rd, ex_result, ex_is_load, ex_writes_rd, ld_rsp_valid, ld_rsp_data,
    output ex_ready, wb_addr, wb_data, wb_wen, busy_mask, err_unexpected_rsp
  );
endinterface

// File: rtl/wb_scoreboard.sv
// Pending-destination mask: every buffered RF write plus the write on the RF port this cycle.
module wb_scoreboard
  import wb_stage_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned RADDR_W = wb_stage_pkg::RADDR_W,
  parameter int unsigned NREGS   = wb_stage_pkg::NUM_REGS
) (
  input  logic [DEPTH-1:0]   i_valid,
  input  logic [DEPTH-1:0]   i_writes_rd,
  input  logic [RADDR_W-1:0] i_rd [DEPTH],
  input  logic               i_wb_wen,
  input  logic [RADDR_W-1:0] i_wb_addr,
  output logic [NREGS-1:0]   o_busy_mask
);
  always_comb begin
    o_busy_mask = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (i_valid[i] && i_writes_rd[i]) o_busy_mask[i_rd[i]] = 1'b1;
    end
    if (i_wb_wen) o_busy_mask[i_wb_addr] = 1'b1;
  end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: in-order completion buffer with out-of-band load fill and
// a single registered register-file write port.
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned DATA_W  = wb_stage_pkg::DATA_W,
  parameter int unsigned RADDR_W = wb_stage_pkg::RADDR_W
) (
  input logic       clk,
  input logic       rst_n,
  wb_stage_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DEPTH-1:0]   r_valid;
  logic [DEPTH-1:0]   r_is_load;
  logic [DEPTH-1:0]   r_writes_rd;
  logic [DEPTH-1:0]   r_filled;
  logic [RADDR_W-1:0] r_rd   [DEPTH];
  logic [DATA_W-1:0]  r_data [DEPTH];
  logic [PTR_W-1:0]   r_head;
  logic [PTR_W-1:0]   r_tail;
  logic [CNT_W-1:0]   r_count;
  logic               r_wb_wen;
  logic [RADDR_W-1:0] r_wb_addr;
  logic [DATA_W-1:0]  r_wb_data;
  logic               r_err;

  logic               w_ready;
  logic               w_accept;
  logic               w_retire;
  logic               w_fill_hit;
  logic [PTR_W-1:0]   w_fill_idx;
  logic [PTR_W-1:0]   w_scan;

  assign w_ready  = (r_count != CNT_W'(DEPTH));
  assign w_accept = bus.ex_valid && w_ready;
  assign w_retire = r_valid[r_head] && r_filled[r_head];

  // Oldest waiting load, scanning from head; this cycle's accept is not yet visible.
  always_comb begin
    w_fill_hit = 1'b0;
    w_fill_idx = '0;
    w_scan     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_scan = r_head + PTR_W'(i);
      if (!w_fill_hit && r_valid[w_scan] && r_is_load[w_scan] && !r_filled[w_scan]) begin
        w_fill_hit = 1'b1;
        w_fill_idx = w_scan;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid     <= '0;
      r_is_load   <= '0;
      r_writes_rd <= '0;
      r_filled    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
      r_head    <= '0;
      r_tail    <= '0;
      r_count   <= '0;
      r_wb_wen  <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_err     <= 1'b0;
    end else begin
      // Accept (free tail slot), fill (valid load) and retire (filled head) never share an entry.
      if (w_accept) begin
        r_valid[r_tail]     <= 1'b1;
        r_rd[r_tail]        <= bus.ex_rd;
        r_data[r_tail]      <= bus.ex_result;
        r_is_load[r_tail]   <= bus.ex_is_load;
        r_writes_rd[r_tail] <= bus.ex_writes_rd;
        r_filled[r_tail]    <= !bus.ex_is_load;
        r_tail              <= r_tail + PTR_W'(1);
      end

      if (bus.ld_rsp_valid) begin
        if (w_fill_hit) begin
          r_data[w_fill_idx]   <= bus.ld_rsp_data;
          r_filled[w_fill_idx] <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end

      r_wb_wen <= w_retire && r_writes_rd[r_head];
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_head          <= r_head + PTR_W'(1);
        if (r_writes_rd[r_head]) begin
          r_wb_addr <= r_rd[r_head];
          r_wb_data <= r_data[r_head];
        end
      end

      unique case ({w_accept, w_retire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  wb_scoreboard #(
    .DEPTH   (DEPTH),
    .RADDR_W (RADDR_W),
    .NREGS   (NUM_REGS)
  ) u_scoreboard (
    .i_valid     (r_valid),
    .i_writes_rd (r_writes_rd),
    .i_rd        (r_rd),
    .i_wb_wen    (r_wb_wen),
    .i_wb_addr   (r_wb_addr),
    .o_busy_mask (bus.busy_mask)
  );

  assign bus.ex_ready           = w_ready;
  assign bus.wb_wen             = r_wb_wen;
  assign bus.wb_addr            = r_wb_addr;
  assign bus.wb_data            = r_wb_data;
  assign bus.err_unexpected_rsp = r_err;
endmodule

// File: tb/tb_wb_stage.sv
// Directed bench for wb_stage: per-cycle vector table plus hand sequences for
// backpressure, stray load responses and mid-operation reset.
module tb_wb_stage;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wb_stage_if #(.DATA_W(32), .RADDR_W(4)) bus ();

  wb_stage #(.DEPTH(4), .DATA_W(32), .RADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] v, rd, res, ld, wr, rv, rdat;
    logic [31:0] rdy, wen, addr, data, busy, err;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input logic [31:0] v, rd, res, ld, wr, rv, rdat,
                              input logic [31:0] rdy, wen, addr, data, busy, err);
    vec_t t;
    t.v = v; t.rd = rd; t.res = res; t.ld = ld; t.wr = wr; t.rv = rv; t.rdat = rdat;
    t.rdy = rdy; t.wen = wen; t.addr = addr; t.data = data; t.busy = busy; t.err = err;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] rdy, wen, addr, data, busy, err);
    chk({tag, ".ready"}, 32'(bus.ex_ready), rdy);
    chk({tag, ".wen"},   32'(bus.wb_wen), wen);
    chk({tag, ".addr"},  32'(bus.wb_addr), addr);
    chk({tag, ".data"},  bus.wb_data, data);
    chk({tag, ".busy"},  32'(bus.busy_mask), busy);
    chk({tag, ".err"},   32'(bus.err_unexpected_rsp), err);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [31:0] v, rd, res, ld, wr);
    bus.ex_valid     = v[0];
    bus.ex_rd        = rd[3:0];
    bus.ex_result    = res;
    bus.ex_is_load   = ld[0];
    bus.ex_writes_rd = wr[0];
  endtask

  task automatic drive_ld(input logic [31:0] rv, rdat);
    bus.ld_rsp_valid = rv[0];
    bus.ld_rsp_data  = rdat;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    drive_ex(0, 0, 0, 0, 0);
    drive_ld(0, 0);

    //            v rd res          ld wr rv rdat         rdy wen addr data         busy     err
    tv.push_back(mk(1, 3, 32'hA5,      0, 1, 0, 0,           1, 0, 0, 0,            16'h0000, 0));
    tv.push_back(mk(0, 0, 0,           0, 0, 0, 0,           1, 0, 0, 0,            16'h0008, 0));
    tv.push_back(mk(0, 0, 0,           0, 0, 0, 0,           1, 1, 3, 32'hA5,       16'h0008, 0));
    tv.push_back(mk(0, 0, 0,           0, 0, 0, 0,           1, 0, 3, 32'hA5,       16'h0000, 0));
    tv.push_back(mk(1, 5, 32'h55,      1, 1, 0, 0,           1, 0, 3, 32'hA5,       16'h0000, 0));
    tv.push_back(mk(1, 6, 32'h11,      0, 1, 0, 0,           1, 0, 3, 32'hA5,       16'h0020, 0));
    tv.push_back(mk(0, 0, 0,           0, 0, 0, 0,           1, 0, 3, 32'hA5,       16'h0060, 0));
    tv.push_back(mk(0, 0, 0,           0, 0, 0, 0,           1, 0, 3, 32'hA5,       16'h0060, 0));
    tv.push_back(mk(0, 0, 0,           0, 0, 1, 32'hDEADBEEF, 1, 0, 3, 32'hA5,      16'h0060, 0));
    tv.push_back(mk(0, 0, 0,           0, 0, 0, 0,           1, 0, 3, 32'hA5,       16'h0060, 0));
    tv.push_back(mk(0, 0, 0,           0, 0, 0, 0,           1, 1, 5, 32'hDEADBEEF, 16'h0060, 0));
    tv.push_back(mk(0, 0, 0,           0, 0, 0, 0,           1, 1, 6, 32'h11,       16'h0040, 0));
    tv.push_back(mk(0, 0, 0,           0, 0, 0, 0,           1, 0, 6, 32'h11,       16'h0000, 0));
    tv.push_back(mk(1, 2, 32'h1,       0, 1, 0, 0,           1, 0, 6, 32'h11,       16'h0000, 0));
    tv.push_back(mk(1, 7, 32'h99,      0, 0, 0, 0,           1, 0, 6, 32'h11,       16'h0004, 0));
    tv.push_back(mk(1, 2, 32'h2,       0, 1, 0, 0,           1, 1, 2, 32'h1,        16'h0004, 0));
    tv.push_back(mk(0, 0, 0,           0, 0, 0, 0,           1, 0, 2, 32'h1,        16'h0004, 0));
    tv.push_back(mk(0, 0, 0,           0, 0, 0, 0,           1, 1, 2, 32'h2,        16'h0004, 0));
    tv.push_back(mk(1, 0, 32'hCAFE,    0, 1, 0, 0,           1, 0, 2, 32'h2,        16'h0000, 0));
    tv.push_back(mk(0, 0, 0,           0, 0, 0, 0,           1, 0, 2, 32'h2,        16'h0001, 0));
    tv.push_back(mk(0, 0, 0,           0, 0, 0, 0,           1, 1, 0, 32'hCAFE,     16'h0001, 0));
    tv.push_back(mk(0, 0, 0,           0, 0, 0, 0,           1, 0, 0, 32'hCAFE,     16'h0000, 0));

    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 1, 0, 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (tv[i]) begin
      drive_ex(tv[i].v, tv[i].rd, tv[i].res, tv[i].ld, tv[i].wr);
      drive_ld(tv[i].rv, tv[i].rdat);
      chk_out($sformatf("vec%0d", i), tv[i].rdy, tv[i].wen, tv[i].addr, tv[i].data,
              tv[i].busy, tv[i].err);
      step();
    end
    drive_ex(0, 0, 0, 0, 0);
    drive_ld(0, 0);

    // Full buffer behind an unanswered load: r1 load then r8..r11 ALU.
    drive_ex(1, 1, 32'h0, 1, 1);
    chk("full.rdy0", 32'(bus.ex_ready), 1);
    step();
    for (int i = 0; i < 3; i++) begin
      drive_ex(1, 32'(8 + i), 32'(32'h100 * (i + 1)), 0, 1);
      chk($sformatf("full.rdy%0d", i + 1), 32'(bus.ex_ready), 1);
      step();
    end
    drive_ex(1, 11, 32'h400, 0, 1);
    chk("full.blocked0", 32'(bus.ex_ready), 0);
    chk("full.busy", 32'(bus.busy_mask), 32'h0702);
    step();
    chk("full.blocked1", 32'(bus.ex_ready), 0);
    drive_ld(1, 32'hAAAA);
    step();
    drive_ld(0, 0);
    chk("full.blocked2", 32'(bus.ex_ready), 0);
    chk("full.nowen", 32'(bus.wb_wen), 0);
    step();
    chk("full.reopen", 32'(bus.ex_ready), 1);
    chk("full.ld.wen", 32'(bus.wb_wen), 1);
    chk("full.ld.addr", 32'(bus.wb_addr), 1);
    chk("full.ld.data", bus.wb_data, 32'hAAAA);
    step();
    drive_ex(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full.wb%0d.wen", i), 32'(bus.wb_wen), 1);
      chk($sformatf("full.wb%0d.addr", i), 32'(bus.wb_addr), 32'(8 + i));
      chk($sformatf("full.wb%0d.data", i), bus.wb_data, 32'(32'h100 * (i + 1)));
      step();
    end
    chk("full.drain.wen", 32'(bus.wb_wen), 0);
    chk("full.drain.busy", 32'(bus.busy_mask), 0);

    // Load response with nothing waiting.
    chk("stray.err0", 32'(bus.err_unexpected_rsp), 0);
    drive_ld(1, 32'h1234);
    step();
    drive_ld(0, 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stray%0d.err", i), 32'(bus.err_unexpected_rsp), 1);
      chk($sformatf("stray%0d.wen", i), 32'(bus.wb_wen), 0);
      chk($sformatf("stray%0d.busy", i), 32'(bus.busy_mask), 0);
      step();
    end

    // Reset with three pending entries (head is an unanswered load).
    drive_ex(1, 12, 32'h0, 1, 1);
    step();
    drive_ex(1, 13, 32'h5, 0, 1);
    step();
    drive_ex(1, 14, 32'h6, 0, 1);
    step();
    drive_ex(0, 0, 0, 0, 0);
    chk("pend.busy", 32'(bus.busy_mask), 32'h7000);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("midrst", 1, 0, 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    drive_ld(1, 32'h77);
    step();
    drive_ld(0, 0);
    for (int i = 0; i < 4; i++) begin
      chk_out($sformatf("post%0d", i), 1, 0, 0, 0, 0, 1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
